// File: rtl/gain_ramp_controller_pkg.sv
// Shared equalizer definitions: band geometry, unity gain, band slicing and ramp FSM states.
package gain_ramp_controller_pkg;

    localparam int unsigned EQ_NUMBER_OF_FILTERS = 8;
    localparam int unsigned EQ_GAIN_BITS         = 2;
    localparam int unsigned EQ_GAIN_FRAC_BITS    = 0;
    localparam logic [EQ_GAIN_BITS-1:0] EQ_UNITY_GAIN = EQ_GAIN_BITS'(1 << EQ_GAIN_FRAC_BITS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

    // LSB position of band `band` inside a packed gain bus
    function automatic int unsigned band_lsb(input int unsigned band, input int unsigned gain_bits);
        return band * gain_bits;
    endfunction

endpackage

// File: rtl/gain_ramp_controller_stepper.sv
// One band: current/target gain registers, moved one LSB toward target per step.
module gain_stepper #(
    parameter int unsigned GAIN_BITS = 2,
    parameter logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 snap,
    input  logic                 step,
    input  logic [GAIN_BITS-1:0] target_in,
    output logic [GAIN_BITS-1:0] gain,
    output logic                 at_target_c,
    output logic                 near_target_c,
    output logic                 match_in_c
);

    logic [GAIN_BITS-1:0] gain_q;
    logic [GAIN_BITS-1:0] target_q;
    logic                 below_c;
    logic                 above_c;

    assign below_c     = $signed(gain_q) < $signed(target_q);
    assign above_c     = $signed(gain_q) > $signed(target_q);
    assign at_target_c = (gain_q == target_q);
    // Within one LSB: the next step lands exactly on target (increment cannot wrap when below)
    assign near_target_c = at_target_c
                        || (below_c && (gain_q + GAIN_BITS'(1)) == target_q)
                        || (above_c && (gain_q - GAIN_BITS'(1)) == target_q);
    assign match_in_c  = (gain_q == target_in);
    assign gain        = gain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_q   <= UNITY;
            target_q <= UNITY;
        end else if (load) begin
            target_q <= target_in;
            if (snap) begin
                gain_q <= target_in;
            end
        end else if (step) begin
            if (below_c) begin
                gain_q <= gain_q + GAIN_BITS'(1);
            end else if (above_c) begin
                gain_q <= gain_q - GAIN_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/gain_ramp_controller.sv
// Ramps per-band gains toward loaded targets, one LSB every STEP_INTERVAL sample strobes.
module gain_ramp_controller
    import gain_ramp_controller_pkg::*;
#(
    parameter int unsigned NUMBER_OF_FILTERS = EQ_NUMBER_OF_FILTERS,
    parameter int unsigned GAIN_BITS         = EQ_GAIN_BITS,
    parameter int unsigned GAIN_FRAC_BITS    = EQ_GAIN_FRAC_BITS,
    parameter int unsigned STEP_INTERVAL     = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sample_en,
    input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] target_gains,
    input  logic                                   load,
    input  logic                                   snap,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gains,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned CNT_W = $clog2(STEP_INTERVAL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_INTERVAL - 1);
    localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1 << GAIN_FRAC_BITS);

    ramp_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_d, done_d;
    logic                   step_c;
    logic [NUMBER_OF_FILTERS-1:0] at_target_c;
    logic [NUMBER_OF_FILTERS-1:0] near_c;
    logic [NUMBER_OF_FILTERS-1:0] match_c;

    // A load in the same cycle takes priority over a due step
    assign step_c = (state_q == RAMP) && sample_en && (cnt_q == CNT_LAST) && !load;

    for (genvar i = 0; i < NUMBER_OF_FILTERS; i++) begin : g_band
        gain_stepper #(
            .GAIN_BITS (GAIN_BITS),
            .UNITY     (UNITY)
        ) u_stepper (
            .clk           (clk),
            .rst_n         (rst_n),
            .load          (load),
            .snap          (snap),
            .step          (step_c),
            .target_in     (target_gains[band_lsb(i, GAIN_BITS) +: GAIN_BITS]),
            .gain          (gains[band_lsb(i, GAIN_BITS) +: GAIN_BITS]),
            .at_target_c   (at_target_c[i]),
            .near_target_c (near_c[i]),
            .match_in_c    (match_c[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (load && snap) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (load) begin
            if (state_q == RAMP && sample_en) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            if (&match_c) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = (state_q == RAMP);
            end else begin
                state_d = RAMP;
            end
        end else if (state_q == RAMP && sample_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (&near_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q == RAMP && (&at_target_c)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
        end
        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_gain_ramp_controller.sv
// Directed bench: expected gain trajectories queued at stimulus time, checked on every gains change.
module tb_gain_ramp_controller;

    localparam int unsigned NF = 8;
    localparam int unsigned GB = 4;
    localparam int unsigned W  = NF * GB;
    localparam logic [W-1:0] UNITY_V = 32'h1111_1111;

    typedef struct packed {
        logic [W-1:0] g;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_en = 1'b0;
    logic [W-1:0] target_gains = '0;
    logic         load = 1'b0;
    logic         snap = 1'b0;
    logic [W-1:0] gains;
    logic         busy;
    logic         done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_base;
    exp_t sb_q[$];
    logic [W-1:0] prev_gains = 32'h1111_1111;

    gain_ramp_controller #(
        .NUMBER_OF_FILTERS (NF),
        .GAIN_BITS         (GB),
        .GAIN_FRAC_BITS    (0),
        .STEP_INTERVAL     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .target_gains (target_gains),
        .load         (load),
        .snap         (snap),
        .gains        (gains),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] g, input logic b, input logic d);
        exp_t e;
        e.g = g; e.busy = b; e.done = d;
        sb_q.push_back(e);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            sample_en = 1'b1;
            @(posedge clk); #1;
            sample_en = 1'b0;
        end
    endtask

    task automatic do_load(input logic [W-1:0] t, input logic s);
        target_gains = t; snap = s; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; snap = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Every change of gains must match the head of the scoreboard, including busy/done
    always @(negedge clk) begin
        exp_t e;
        if (gains !== prev_gains) begin
            total++;
            assert (sb_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_change obs=%h exp=no_change", gains);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_gains", gains, e.g);
                chk("sb_busy", W'(busy), W'(e.busy));
                chk("sb_done", W'(done), W'(e.done));
            end
        end
        if (done === 1'b1) done_cnt++;
        prev_gains = gains;
    end

    initial begin
        // 1: reset state, strobes without load do nothing
        #12;
        chk("rst_gains", gains, UNITY_V);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        strobes(20);
        chk("idle_gains", gains, UNITY_V);
        chk("idle_busy", W'(busy), '0);

        // 2: band0 ramps up 1 -> 4
        done_base = done_cnt;
        do_load(32'h1111_1114, 1'b0);
        chk("t2_busy", W'(busy), W'(1));
        push(32'h1111_1112, 1'b1, 1'b0);
        push(32'h1111_1113, 1'b1, 1'b0);
        push(32'h1111_1114, 1'b0, 1'b1);
        strobes(3);
        chk("t2_no_early", gains, UNITY_V);
        strobes(9);
        chk("t2_final", gains, 32'h1111_1114);
        idle(1);
        chk("t2_done_low", W'(done), '0);
        chk("t2_busy_low", W'(busy), '0);
        chk("t2_done_cnt", W'(done_cnt - done_base), W'(1));

        // 3: band3 ramps down through zero 1 -> -3
        done_base = done_cnt;
        do_load(32'h1111_D114, 1'b0);
        push(32'h1111_0114, 1'b1, 1'b0);
        push(32'h1111_F114, 1'b1, 1'b0);
        push(32'h1111_E114, 1'b1, 1'b0);
        push(32'h1111_D114, 1'b0, 1'b1);
        strobes(16);
        idle(2);
        chk("t3_final", gains, 32'h1111_D114);
        chk("t3_done_cnt", W'(done_cnt - done_base), W'(1));

        // 4: retarget mid-ramp keeps the interval counter running
        push(UNITY_V, 1'b0, 1'b0);
        do_load(UNITY_V, 1'b1);
        done_base = done_cnt;
        do_load(32'h1111_1114, 1'b0);
        push(32'h1111_1112, 1'b1, 1'b0);
        strobes(6);
        do_load(32'h1111_1110, 1'b0);
        chk("t4_retgt_busy", W'(busy), W'(1));
        push(32'h1111_1111, 1'b1, 1'b0);
        push(32'h1111_1110, 1'b0, 1'b1);
        strobes(2);
        chk("t4_no_restart", gains, 32'h1111_1111);
        strobes(4);
        idle(2);
        chk("t4_final", gains, 32'h1111_1110);
        chk("t4_done_cnt", W'(done_cnt - done_base), W'(1));

        // 5: snap load, then identical load is a no-op
        done_base = done_cnt;
        push(32'h78A5_C3F1, 1'b0, 1'b0);
        do_load(32'h78A5_C3F1, 1'b1);
        chk("t5_snap_gains", gains, 32'h78A5_C3F1);
        chk("t5_snap_busy", W'(busy), '0);
        chk("t5_snap_done", W'(done), '0);
        do_load(32'h78A5_C3F1, 1'b0);
        chk("t5_same_busy", W'(busy), '0);
        strobes(8);
        chk("t5_same_gains", gains, 32'h78A5_C3F1);
        chk("t5_done_cnt", W'(done_cnt - done_base), '0);

        // 6a: asynchronous reset mid-ramp
        done_base = done_cnt;
        do_load(UNITY_V, 1'b0);
        push(32'h69B4_D201, 1'b1, 1'b0);
        strobes(6);
        push(UNITY_V, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_gains", gains, UNITY_V);
        chk("t6_rst_busy", W'(busy), '0);
        @(posedge clk); #3; rst_n = 1'b1;
        idle(3);
        chk("t6_rst_done_cnt", W'(done_cnt - done_base), '0);

        // 6b: load coincident with a step-eligible strobe suppresses that step
        do_load(32'h1111_1113, 1'b0);
        strobes(3);
        sample_en = 1'b1;
        do_load(32'h1111_1115, 1'b0);
        sample_en = 1'b0;
        chk("t6_load_wins", gains, UNITY_V);
        strobes(1);
        chk("t6_cnt_wrapped", gains, UNITY_V);
        push(32'h1111_1112, 1'b1, 1'b0);
        push(32'h1111_1113, 1'b1, 1'b0);
        push(32'h1111_1114, 1'b1, 1'b0);
        push(32'h1111_1115, 1'b0, 1'b1);
        strobes(15);
        idle(2);
        chk("t6_final", gains, 32'h1111_1115);
        chk("sb_empty", W'(sb_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gain_ramp_controller.md
Name: gain_ramp_controller

Overview:
- Upstream neighbour of the per-band amplifier in the resample2.0 equalizer.
- Owns the packed `gains` bus that the amplifier consumes. Takes new per-band target gains from the control side (keys/UART decoder).
- Walks each band's current gain toward its target one LSB at a time, paced by the audio sample strobe. This avoids zipper noise and clicks from step gain changes.
- Gains change only on sample boundaries, so every filter sees a constant gain within a sample.

Parameters:
- NUMBER_OF_FILTERS, 8, number of bands (width multiplier of both gain buses).
- GAIN_BITS, 2, signed two's-complement width of one band gain; same format as the amplifier's gain input.
- GAIN_FRAC_BITS, 0, fractional bits of a gain; only used to form the unity reset value.
- STEP_INTERVAL, 1024, number of `sample_en` strobes between successive one-LSB steps; must be ≥1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sample_en, input, 1, one-cycle strobe per audio sample.
- target_gains, input, NUMBER_OF_FILTERS*GAIN_BITS, packed signed targets; band i occupies bits [(i+1)*GAIN_BITS-1 : i*GAIN_BITS].
- load, input, 1, one-cycle pulse that latches `target_gains`.
- snap, input, 1, qualifies `load`: jump immediately instead of ramping.
- gains, output, NUMBER_OF_FILTERS*GAIN_BITS, registered current gains; same packing; drives the amplifier.
- busy, output, 1, high while any band's current gain ≠ its target.
- done, output, 1, one-cycle pulse when a ramp completes.

Behaviour:

Reset (rst_n=0, asynchronous):
- Every band of `gains` and of the internal target register = unity, i.e. 1 << GAIN_FRAC_BITS truncated to GAIN_BITS.
- Interval counter = 0; busy = 0; done = 0.
- Reset mid-ramp abandons the ramp; no done pulse.

States: IDLE, RAMP.

load, snap=0, at edge t:
- Target register takes `target_gains`, visible at t+1.
- If any band differs from current, go to RAMP; busy = 1 from t+1.
- Otherwise stay IDLE; busy stays 0; no done pulse.

load, snap=1, at edge t:
- Both the target register and `gains` take `target_gains` at t+1.
- State = IDLE; counter cleared; busy = 0; done = 0.

RAMP operation:
- Counter increments on each `sample_en`.
- On the `sample_en` where counter == STEP_INTERVAL-1:
  - counter wraps to 0;
  - every band with current < target (signed compare) increments by 1;
  - every band with current > target decrements by 1;
  - equal bands hold.
- Updated `gains` are visible the cycle after that `sample_en` edge.
- No step ever overshoots the target, so no saturation is needed.
- The first step occurs on the STEP_INTERVAL-th strobe after entering RAMP.

Ramp completion:
- When a step makes all bands equal to their targets:
  - go to IDLE;
  - busy = 0 and done = 1, both in the same cycle `gains` shows the final value;
  - done returns to 0 one cycle later.

Retarget while busy:
- load (snap=0) in RAMP replaces targets and keeps the counter running (no restart), so pacing stays regular.
- If the new targets equal the current gains, go to IDLE with a done pulse on the next cycle.

Simultaneous events and counter rules:
- load and step-eligible `sample_en` in the same cycle: load wins; no step that cycle; counter still advances.
- `sample_en` is ignored in IDLE; the counter is held at 0.
- Counter width = clog2(STEP_INTERVAL)+1.

Decomposition:
- Shared equalizer package holds NUMBER_OF_FILTERS, GAIN_BITS, GAIN_FRAC_BITS, the unity-gain constant, and the band-slice index helper. The amplifier uses the same package.
- One natural sub-module: `gain_stepper`, a single band. It holds current/target registers and the signed compare; `step` moves one LSB toward target; it outputs `at_target`. Generate NUMBER_OF_FILTERS copies. The top holds the counter, the FSM, and the AND-reduction of `at_target` to form busy/done.

Test Plan (STEP_INTERVAL=4, GAIN_BITS=4, GAIN_FRAC_BITS=0 unless noted):
1. Reset → all bands gains=1, busy=0, done=0. Deassert rst_n, no load, 20 strobes → gains unchanged.
2. load band0 target=4, others 1, snap=0 → busy=1 next cycle; band0 = 2, 3, 4 after strobes 4, 8, 12; done pulses once, coincident with 4; busy=0 after.
3. load band3 target=-3 from 1 → band3 steps 0, -1, -2, -3 at 4-strobe intervals; other bands constant; signed decrement correct across zero.
4. Mid-ramp (band0 at 2, heading to 4) load target=0 → band0 goes to 1, then 0 at the next step boundaries; counter not restarted; exactly one done pulse.
5. load with snap=1, targets {7,-8,...} → gains equal targets next cycle; busy=0; done=0. Then a load of identical values → no busy, no done.
6. Assert rst_n=0 asynchronously mid-ramp (off clock edge) → gains=unity immediately, busy=0, no done. Separately: load coincident with a step-eligible strobe → no step that cycle.
